// File: rtl/enum_seq.sv
// Parametrised N-member enumerated sequencer: binary or one-hot encoding, up/down stepping,
// synchronous load and a modulo wrap counter. Define ENUM_SEQ_ASSERT_EN to compile in assertions.
module enum_seq #(
  parameter int NSTATES   = 4,
  parameter int ONEHOT    = 0,
  parameter int CNT_W     = 8,
  parameter int RESET_IDX = 0,
  localparam int IDX_W    = (NSTATES > 2) ? $clog2(NSTATES) : 1,
  localparam int SW       = (ONEHOT != 0) ? NSTATES : IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic [SW-1:0]    state,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic [CNT_W-1:0] laps,
  output logic             err
);

  function automatic logic [SW-1:0] enc(input logic [IDX_W-1:0] k);
    if (ONEHOT != 0) return SW'(1) << k;
    return SW'(k);
  endfunction

  function automatic logic [IDX_W-1:0] dec(input logic [SW-1:0] s);
    logic [IDX_W-1:0] k;
    k = '0;
    if (ONEHOT != 0) begin
      for (int i = 0; i < SW; i++) if (s[i]) k = IDX_W'(i);
    end else begin
      k = IDX_W'(s);
    end
    return k;
  endfunction

  function automatic logic legal(input logic [SW-1:0] s);
    if (ONEHOT != 0) return $onehot(s);
    return 32'(s) < 32'(NSTATES);
  endfunction

  localparam logic [SW-1:0] ENC_RESET = enc(IDX_W'(RESET_IDX));

  // Only the boundary members need names; interior members are reached through enc().
  typedef enum logic [SW-1:0] {
    S_FIRST = enc(IDX_W'(0)),
    S_LAST  = enc(IDX_W'(NSTATES - 1))
  } edge_e;

  logic [SW-1:0]    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] laps_q, laps_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] cur_idx, nxt_idx;
  logic             cur_legal, at_first, at_last, step_wrap;

  always_comb begin
    cur_idx   = dec(state_q);
    cur_legal = legal(state_q);
    at_first  = (state_q == S_FIRST);
    at_last   = (state_q == S_LAST);
    // With two members every step crosses the s[1]/s[0] boundary, whichever direction.
    step_wrap = (NSTATES == 2) || (dir ? at_first : at_last);
    if (dir) nxt_idx = at_first ? IDX_W'(NSTATES - 1) : cur_idx - IDX_W'(1);
    else     nxt_idx = at_last  ? '0                  : cur_idx + IDX_W'(1);

    state_d = state_q;
    idx_d   = idx_q;
    laps_d  = laps_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    if (!cur_legal) begin
      state_d = ENC_RESET;
      idx_d   = IDX_W'(RESET_IDX);
      err_d   = 1'b1;
    end else if (load) begin
      if (32'(load_idx) < 32'(NSTATES)) begin
        state_d = enc(load_idx);
        idx_d   = load_idx;
      end else begin
        err_d   = 1'b1;
      end
    end else if (en) begin
      state_d = enc(nxt_idx);
      idx_d   = nxt_idx;
      wrap_d  = step_wrap;
      if (step_wrap) laps_d = laps_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENC_RESET;
      idx_q   <= IDX_W'(RESET_IDX);
      laps_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      laps_q  <= laps_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
`ifdef ENUM_SEQ_ASSERT_EN
    if (!rst) begin
      case (cur_legal)
        1'b1:    assert (!wrap_d || at_first || at_last);
        default: assert (1'b0);
      endcase
    end
    assert ((ONEHOT != 0) || (S_FIRST == '0));
`endif
  end

`ifdef ENUM_SEQ_ASSERT_EN
  always_comb begin
    if (!rst) begin
      assert (32'(idx_q) < 32'(NSTATES));
      assert (state_q == enc(idx_q));
      if (ONEHOT != 0) assert ($onehot(state_q));
    end
  end
`endif

  assign state = state_q;
  assign idx   = idx_q;
  assign wrap  = wrap_q;
  assign laps  = laps_q;
  assign err   = err_q;

endmodule

// File: tb/tb_enum_seq.sv
// Bench for enum_seq: seven differently parametrised instances share one stimulus stream and
// are compared each cycle against an index/lap-count reference model.
module tb_enum_seq;
  localparam int ND = 7;
  localparam int PN[ND] = '{4, 5, 3, 2, 4, 4, 16};
  localparam int PO[ND] = '{0, 1, 0, 0, 0, 1, 0};
  localparam int PC[ND] = '{8, 8, 8, 2, 8, 8, 3};
  localparam int PR[ND] = '{0, 0, 0, 0, 2, 1, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [3:0] load_idx = 4'd0;

  logic [31:0] st_o[ND], ix_o[ND], lp_o[ND];
  logic        wr_o[ND], er_o[ND];

  for (genvar g = 0; g < ND; g++) begin : gen_dut
    localparam int IW = (PN[g] > 2) ? $clog2(PN[g]) : 1;
    localparam int SW = (PO[g] != 0) ? PN[g] : IW;
    logic [SW-1:0]    s;
    logic [IW-1:0]    i;
    logic [PC[g]-1:0] l;
    logic             w, e;
    enum_seq #(.NSTATES(PN[g]), .ONEHOT(PO[g]), .CNT_W(PC[g]), .RESET_IDX(PR[g])) u (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_idx(load_idx[IW-1:0]),
      .state(s), .idx(i), .wrap(w), .laps(l), .err(e));
    assign st_o[g] = 32'(s);
    assign ix_o[g] = 32'(i);
    assign lp_o[g] = 32'(l);
    assign wr_o[g] = w;
    assign er_o[g] = e;
  end

  int checks = 0, failures = 0;
  int m_idx[ND], m_laps[ND];
  bit m_wrap[ND], m_err[ND], illegal[ND], skip_state[ND];

  function automatic int iw(int k);
    return (PN[k] > 2) ? $clog2(PN[k]) : 1;
  endfunction

  // Reference: members are plain integers 0..N-1, encoding applied only when comparing.
  task automatic model_step();
    for (int k = 0; k < ND; k++) begin
      int li;
      li = int'(load_idx) % (1 << iw(k));
      m_wrap[k] = 1'b0;
      m_err[k]  = 1'b0;
      if (rst) begin
        m_idx[k] = PR[k]; m_laps[k] = 0;
      end else if (illegal[k]) begin
        m_idx[k] = PR[k]; m_err[k] = 1'b1;
      end else if (load) begin
        if (li < PN[k]) m_idx[k] = li;
        else m_err[k] = 1'b1;
      end else if (en) begin
        int n;
        n = dir ? m_idx[k] - 1 : m_idx[k] + 1;
        m_wrap[k] = (PN[k] == 2) || n < 0 || n >= PN[k];
        m_idx[k]  = (n + PN[k]) % PN[k];
        if (m_wrap[k]) m_laps[k] = (m_laps[k] + 1) % (1 << PC[k]);
      end
    end
  endtask

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < ND; k++) begin
      if (!skip_state[k])
        chk("state", k, st_o[k], PO[k] != 0 ? (32'd1 << m_idx[k]) : 32'(m_idx[k]));
      chk("idx",  k, ix_o[k], 32'(m_idx[k]));
      chk("laps", k, lp_o[k], 32'(m_laps[k]));
      chk("wrap", k, 32'(wr_o[k]), 32'(m_wrap[k]));
      chk("err",  k, 32'(er_o[k]), 32'(m_err[k]));
    end
  endtask

  task automatic cycle(bit r, bit e, bit d, bit l, logic [3:0] li);
    rst = r; en = e; dir = d; load = l; load_idx = li;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 0, 4'd0);
    cycle(1, 1, 0, 1, 4'd1);
    chk("rst_idx_ri2", 4, ix_o[4], 32'd2);
    chk("rst_state_oh", 1, st_o[1], 32'h1);

    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 4'd0);
    chk("up5_idx", 0, ix_o[0], 32'd1);
    chk("up5_laps", 0, lp_o[0], 32'd1);
    chk("n2_laps_mod", 3, lp_o[3], 32'd1);
    chk("n2_wrap_cont", 3, 32'(wr_o[3]), 32'd1);

    cycle(1, 0, 0, 0, 4'd0);
    cycle(0, 1, 1, 0, 4'd0);
    chk("dn1_state", 1, st_o[1], 32'h10);
    chk("dn1_wrap", 1, 32'(wr_o[1]), 32'd1);
    cycle(0, 1, 1, 0, 4'd0);
    chk("dn2_state", 1, st_o[1], 32'h08);
    chk("dn2_laps", 1, lp_o[1], 32'd1);

    cycle(0, 1, 0, 1, 4'd3);
    chk("ldbad_err", 2, 32'(er_o[2]), 32'd1);
    chk("ldbad_idx", 2, ix_o[2], 32'd1);
    cycle(0, 1, 0, 1, 4'd2);
    chk("ldok_idx", 2, ix_o[2], 32'd2);
    chk("ldok_err", 2, 32'(er_o[2]), 32'd0);

    cycle(1, 0, 0, 0, 4'd0);
    cycle(0, 1, 1, 0, 4'd0);
    chk("mid_pre_idx", 4, ix_o[4], 32'd1);
    cycle(1, 1, 0, 1, 4'd0);
    chk("mid_rst_idx", 4, ix_o[4], 32'd2);
    chk("mid_rst_laps", 4, lp_o[4], 32'd0);

    for (int i = 0; i < 400; i++) begin
      bit r, e, d, l;
      r = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      cycle(r, e, d, l, 4'($urandom_range(0, 15)));
    end

    // Illegal one-hot encoding held across one edge: recovery must beat load and en.
    force gen_dut[5].u.state_q = 4'b0110;
    illegal[5] = 1'b1;
    skip_state[5] = 1'b1;
    cycle(0, 1, 0, 1, 4'd0);
    chk("ill_idx", 5, ix_o[5], 32'd1);
    chk("ill_err", 5, 32'(er_o[5]), 32'd1);
    release gen_dut[5].u.state_q;
    illegal[5] = 1'b0;
    cycle(1, 0, 0, 0, 4'd0);
    skip_state[5] = 1'b0;
    cycle(0, 1, 0, 0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
